// File: rtl/seg7_value_port.sv
// seg7_value_port: CPU-writable shadow register that feeds the two seven-segment
// scan drivers. The shadow is copied to the display outputs only on frame_sync,
// so a scan never shows a half-updated value. COUNT mode auto-increments the
// shadow on a prescaled tick.
module seg7_value_port #(
  parameter int          TICK_DIV    = 100000,
  parameter logic [31:0] RESET_VALUE = 32'h1234ABCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        frame_sync,
  output logic [15:0] disp_hi,
  output logic [15:0] disp_lo,
  output logic [7:0]  dp_mask,
  output logic        committed
);

  typedef enum logic [1:0] {
    MODE_MANUAL   = 2'b00,
    MODE_COUNT    = 2'b01,
    MODE_HOLD     = 2'b10,
    MODE_HOLD_ALT = 2'b11
  } mode_e;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_DPMASK = 2'd2;

  localparam int            CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  mode_e         mode;
  logic [31:0]   shadow;
  logic [31:0]   disp;
  logic          wr_pend;
  logic [CW-1:0] tick_cnt;

  logic accept;
  logic value_wr;
  logic tick;
  logic do_commit;

  // Decode of this cycle's write, tick and commit conditions.
  always_comb begin
    accept    = wr_valid && !wr_pend;
    value_wr  = accept && (wr_addr == ADDR_VALUE);
    tick      = (mode == MODE_COUNT) && (tick_cnt == TICK_LAST);
    // HOLD and its alias both have bit 1 set.
    do_commit = frame_sync && !mode[1];
  end

  // Prescaler for COUNT mode; parked at zero in every other mode.
  always_ff @(posedge clk) begin
    if (rst || mode != MODE_COUNT || tick) tick_cnt <= '0;
    else                                   tick_cnt <= tick_cnt + CW'(1);
  end

  // Shadow register: an accepted VALUE write takes priority over a tick.
  always_ff @(posedge clk) begin
    if (rst)           shadow <= RESET_VALUE;
    else if (value_wr) shadow <= merge_bytes(shadow, wr_data, wr_be);
    else if (tick)     shadow <= shadow + 32'd1;
  end

  // Control registers: mode and decimal-point mask take effect immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= MODE_MANUAL;
      dp_mask <= 8'h00;
    end else if (accept && wr_be[0]) begin
      if (wr_addr == ADDR_CTRL)   mode    <= mode_e'(wr_data[1:0]);
      if (wr_addr == ADDR_DPMASK) dp_mask <= wr_data[7:0];
    end
  end

  // Pending flag throttles the CPU to one VALUE write per frame; set beats clear.
  always_ff @(posedge clk) begin
    if (rst)             wr_pend <= 1'b0;
    else if (value_wr)   wr_pend <= 1'b1;
    else if (frame_sync) wr_pend <= 1'b0;
  end

  // Frame-synchronised commit; uses the pre-write shadow on a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp      <= RESET_VALUE;
      committed <= 1'b0;
    end else begin
      committed <= do_commit;
      if (do_commit) disp <= shadow;
    end
  end

  assign wr_ready = ~wr_pend;
  assign disp_hi  = disp[31:16];
  assign disp_lo  = disp[15:0];

endmodule

// File: tb/tb_seg7_value_port.sv
// Directed bench for seg7_value_port with a short prescaler (TICK_DIV=4).
module tb_seg7_value_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [1:0]  wr_addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_be = 4'h0;
  logic        frame_sync = 1'b0;
  logic [15:0] disp_hi;
  logic [15:0] disp_lo;
  logic [7:0]  dp_mask;
  logic        committed;

  int checks = 0;
  int errors = 0;

  seg7_value_port #(.TICK_DIV(4), .RESET_VALUE(32'h1234ABCD)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .frame_sync(frame_sync),
    .disp_hi(disp_hi), .disp_lo(disp_lo), .dp_mask(dp_mask),
    .committed(committed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_valid = 1'b0; wr_be = 4'h0;
  endtask

  task automatic fsync();
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_disp", {disp_hi, disp_lo}, 32'h1234ABCD);
    chk("rst_dp", {24'd0, dp_mask}, 32'h0);
    chk("rst_committed", {31'd0, committed}, 32'd0);
    chk("rst_ready", {31'd0, wr_ready}, 32'd1);

    // MANUAL: write held off the display until frame_sync
    write(2'd0, 32'hDEADBEEF, 4'hF);
    chk("wr_ready_low", {31'd0, wr_ready}, 32'd0);
    for (int i = 0; i < 50; i++) step();
    chk("stall_disp", {disp_hi, disp_lo}, 32'h1234ABCD);
    chk("stall_ready", {31'd0, wr_ready}, 32'd0);
    chk("stall_committed", {31'd0, committed}, 32'd0);
    fsync();
    chk("commit_hi", {16'd0, disp_hi}, 32'h0000DEAD);
    chk("commit_lo", {16'd0, disp_lo}, 32'h0000BEEF);
    chk("commit_pulse", {31'd0, committed}, 32'd1);
    chk("commit_ready", {31'd0, wr_ready}, 32'd1);
    step();
    chk("commit_pulse_end", {31'd0, committed}, 32'd0);

    // Byte enables
    write(2'd0, 32'h00000000, 4'hF);
    fsync();
    chk("zero_disp", {disp_hi, disp_lo}, 32'h00000000);
    write(2'd0, 32'hAABBCCDD, 4'b0101);
    fsync();
    chk("be_merge", {disp_hi, disp_lo}, 32'h00BB00DD);

    // COUNT mode with wrap; frame_sync every 4 cycles
    write(2'd0, 32'hFFFFFFFE, 4'hF);
    fsync();
    chk("cnt_start", {disp_hi, disp_lo}, 32'hFFFFFFFE);
    write(2'd1, 32'd1, 4'h1);              // CTRL edge E0
    step(); step(); step(); step();        // E1..E4, increment lands at E4
    fsync();                               // E5
    chk("cnt_ffff", {disp_hi, disp_lo}, 32'hFFFFFFFF);
    chk("cnt_pulse", {31'd0, committed}, 32'd1);
    step(); step(); step();                // E6..E8, wrap lands at E8
    fsync();                               // E9
    chk("cnt_wrap", {disp_hi, disp_lo}, 32'h00000000);

    // VALUE write on the tick edge (E12): write wins over increment
    step(); step();                        // E10, E11
    write(2'd0, 32'h00000100, 4'hF);       // E12
    fsync();                               // E13
    chk("wr_vs_tick", {disp_hi, disp_lo}, 32'h00000100);

    // VALUE write coincident with frame_sync in MANUAL
    write(2'd1, 32'd0, 4'h1);
    frame_sync = 1'b1;
    write(2'd0, 32'hCAFEF00D, 4'hF);
    frame_sync = 1'b0;
    chk("coll_old_disp", {disp_hi, disp_lo}, 32'h00000100);
    chk("coll_pend", {31'd0, wr_ready}, 32'd0);
    fsync();
    chk("coll_new_disp", {disp_hi, disp_lo}, 32'hCAFEF00D);
    chk("coll_ready", {31'd0, wr_ready}, 32'd1);

    // HOLD: frame_sync clears pend only
    write(2'd1, 32'd2, 4'h1);
    write(2'd0, 32'h00000005, 4'hF);
    fsync();
    chk("hold_disp", {disp_hi, disp_lo}, 32'hCAFEF00D);
    chk("hold_no_pulse", {31'd0, committed}, 32'd0);
    chk("hold_ready", {31'd0, wr_ready}, 32'd1);
    write(2'd1, 32'd0, 4'h1);
    fsync();
    chk("unhold_disp", {disp_hi, disp_lo}, 32'h00000005);
    chk("unhold_pulse", {31'd0, committed}, 32'd1);

    // Reserved address ignored; DPMASK immediate
    write(2'd3, 32'hFFFFFFFF, 4'hF);
    chk("rsvd_ready", {31'd0, wr_ready}, 32'd1);
    write(2'd2, 32'h000000FF, 4'h1);
    chk("dp_mask", {24'd0, dp_mask}, 32'h000000FF);

    // Reset while pending in COUNT mode, with coincident frame_sync
    write(2'd1, 32'd1, 4'h1);
    write(2'd0, 32'h00000077, 4'hF);
    chk("pre_rst_pend", {31'd0, wr_ready}, 32'd0);
    rst = 1'b1; frame_sync = 1'b1;
    step();
    rst = 1'b0; frame_sync = 1'b0;
    chk("mid_rst_disp", {disp_hi, disp_lo}, 32'h1234ABCD);
    chk("mid_rst_dp", {24'd0, dp_mask}, 32'h0);
    chk("mid_rst_ready", {31'd0, wr_ready}, 32'd1);
    chk("mid_rst_committed", {31'd0, committed}, 32'd0);
    for (int i = 0; i < 6; i++) step();
    fsync();
    chk("post_rst_manual", {disp_hi, disp_lo}, 32'h1234ABCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
